booth_mul_pipe: RTL and testbench

Parametrised, two-stage pipelined radix-4 Booth multiplier with valid/ready handshakes on both sides, per-operation signed/unsigned mode, a pass-through tag and a flush input. It is the next-generation multiply unit for the CPU execute stage. It accepts one operation per cycle and returns the full 2×WIDTH product two cycles later unless stalled. Internally it keeps the partial-product generation and carry-save compression scheme and adds registered pipeline stages and flow control.

---
 rtl/booth_mul_pipe_if.sv | 44 ++++
 rtl/booth_mul_pipe.sv | 207 ++++++++++++++++++++
 tb/tb_booth_mul_pipe.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mul_pipe_if.sv
// booth_mul_pipe_if: operation/result bus of the pipelined Booth multiplier.
//
// Handshake rule for both directions: a transfer happens on a rising clock
// edge where valid and ready are both high. A producer holding valid high
// keeps its payload stable until that edge. in_ready may depend on out_ready,
// flush and reset in the same cycle.
//
// Signals:
//   in_valid / in_ready   operation offered / unit can accept it
//   in_signed             1: operands are two's-complement, 0: unsigned
//   in_x, in_y            multiplicand, multiplier (WIDTH bits)
//   in_tag                opaque tag returned with the result
//   flush                 discard every in-flight operation
//   out_valid / out_ready result present / consumer takes it
//   out_result            full 2*WIDTH product
//   out_tag               tag of out_result
//
// Modports: master = the client driving operations, slave = the multiplier.
interface booth_mul_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) ();
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   in_x;
  logic [WIDTH-1:0]   in_y;
  logic [TAG_W-1:0]   in_tag;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_result;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_signed, in_x, in_y, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_signed, in_x, in_y, in_tag, flush, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/booth_mul_pipe.sv
// booth_mul_pipe: two-stage pipelined radix-4 Booth multiplier.
//
// Stage 1 builds the Booth partial products of the current operation and
// compresses them with a carry-save (Wallace) tree down to two vectors plus
// one carry-in bit, registered into S1. Stage 2 adds those with a single
// carry-propagate adder and registers the product into S2, which drives the
// output side of the bus. One operation per cycle, two in flight at most.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset (priority over flush)
//   bus    booth_mul_pipe_if slave modport; its WIDTH/TAG_W must match the
//          parameters given here. WIDTH must be even and at least 4.
//
// The Booth arithmetic is carried out modulo 2^(2*WIDTH): only the low
// 2*WIDTH bits of the result are kept, and no bit above that position can
// influence them, so rows are built at that width.
module booth_mul_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input logic           clk,
  input logic           reset,
  booth_mul_pipe_if.slave bus
);

  localparam int E     = WIDTH + 2;   // extended operand width
  localparam int NPP   = E / 2;       // number of Booth partial products
  localparam int NROWS = NPP + 1;     // partial products + negation-carry row
  localparam int RW    = 2 * WIDTH;   // row width actually kept

  // Rows left after lvl levels of 3:2 compression.
  function automatic int cnt_at(input int lvl);
    int n;
    n = NROWS;
    for (int k = 0; k < lvl; k++) n = (n / 3) * 2 + n % 3;
    return n;
  endfunction

  // Levels needed to bring NROWS down to two rows.
  function automatic int tree_depth();
    int n;
    int d;
    n = NROWS;
    d = 0;
    for (int k = 0; k < 64; k++) begin
      if (n > 2) begin
        n = (n / 3) * 2 + n % 3;
        d++;
      end
    end
    return d;
  endfunction

  localparam int DEPTH = tree_depth();

  // ---------------------------------------------------------------------
  // Stage 1: operand extension and Booth recoding
  // ---------------------------------------------------------------------
  logic          sx;
  logic          sy;
  logic [RW-1:0] x1;
  logic [RW-1:0] x2;
  logic [E:0]    yb;       // extended multiplier with y[-1] = 0 appended

  logic [2:0]    grp [NPP];
  logic [RW-1:0] mag [NPP];
  logic          neg [NPP];
  logic [RW-1:0] pp  [NROWS];
  logic [RW-1:0] neg_row;
  logic          cin0;

  always_comb begin
    sx = bus.in_signed & bus.in_x[WIDTH-1];
    sy = bus.in_signed & bus.in_y[WIDTH-1];
    x1 = {{(RW-WIDTH){sx}}, bus.in_x};
    x2 = x1 << 1;
    yb = {sy, sy, bus.in_y, 1'b0};
  end

  // Each negative partial product is entered as ~m shifted into place, and
  // the "+1" of the two's-complement lands at bit 2i. Those bits never
  // overlap, so they form one extra row; the bit of the lowest product is
  // pulled out as the separate carry-in consumed by the final adder.
  always_comb begin
    neg_row = '0;
    for (int i = 0; i < NPP; i++) begin
      grp[i] = yb[2*i +: 3];
      mag[i] = '0;
      neg[i] = 1'b0;
      case (grp[i])
        3'b001, 3'b010: mag[i] = x1;
        3'b011:         mag[i] = x2;
        3'b100: begin
          mag[i] = x2;
          neg[i] = 1'b1;
        end
        3'b101, 3'b110: begin
          mag[i] = x1;
          neg[i] = 1'b1;
        end
        default: ;     // 000 and 111 select zero
      endcase
      pp[i] = (neg[i] ? ~mag[i] : mag[i]) << (2 * i);
      if (i != 0) neg_row[2*i] = neg[i];
    end
    pp[NPP] = neg_row;
    cin0    = neg[0];
  end

  // ---------------------------------------------------------------------
  // Stage 1: Wallace tree. At each level rows are taken in groups of three
  // and replaced by a sum row and a shifted carry row; leftover rows pass
  // straight through to the next level.
  // ---------------------------------------------------------------------
  logic [RW-1:0] cur [NROWS];
  logic [RW-1:0] nxt [NROWS];
  logic [RW-1:0] vec_a;
  logic [RW-1:0] vec_b;

  always_comb begin
    cur = pp;
    nxt = '{default: '0};
    for (int l = 0; l < DEPTH; l++) begin
      nxt = '{default: '0};
      for (int g = 0; g < NROWS / 3; g++) begin
        if (3 * g + 3 <= cnt_at(l)) begin
          nxt[2*g]   = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
          nxt[2*g+1] = ((cur[3*g] & cur[3*g+1]) |
                        (cur[3*g] & cur[3*g+2]) |
                        (cur[3*g+1] & cur[3*g+2])) << 1;
        end
      end
      for (int r = 0; r < NROWS; r++) begin
        if (r >= 3 * (cnt_at(l) / 3) && r < cnt_at(l))
          nxt[r - cnt_at(l) / 3] = cur[r];
      end
      cur = nxt;
    end
    vec_a = cur[0];
    vec_b = cur[1];
  end

  // ---------------------------------------------------------------------
  // Pipeline registers and flow control
  // ---------------------------------------------------------------------
  logic             s1_valid;
  logic [RW-1:0]    s1_a;
  logic [RW-1:0]    s1_b;
  logic             s1_cin;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic [RW-1:0]    s2_result;
  logic [TAG_W-1:0] s2_tag;

  logic             s2_free;
  logic             s1_adv;
  logic             ready;
  logic             accept;
  logic [RW-1:0]    sum2;

  assign s2_free = !s2_valid | bus.out_ready;
  assign s1_adv  = s1_valid & s2_free;
  assign ready   = !reset & !bus.flush & (!s1_valid | s2_free);
  assign accept  = bus.in_valid & ready;
  assign sum2    = s1_a + s1_b + {{(RW-1){1'b0}}, s1_cin};

  // S1 payload needs no reset: it is only observed once s1_valid is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a   <= vec_a;
      s1_b   <= vec_b;
      s1_cin <= cin0;
      s1_tag <= bus.in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_tag    <= '0;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (accept)      s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;

      if (s1_adv) begin
        s2_valid  <= 1'b1;
        s2_result <= sum2;
        s2_tag    <= s1_tag;
      end else if (bus.out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = ready;
  assign bus.out_valid  = s2_valid;
  assign bus.out_result = s2_result;
  assign bus.out_tag    = s2_tag;

endmodule

// File: tb/tb_booth_mul_pipe.sv
// tb_booth_mul_pipe: scoreboard bench for booth_mul_pipe.
// A 32-bit instance gets directed operations (corner products, latency,
// back-to-back issue, capacity under backpressure, flush, reset); an 8-bit
// instance gets corner pairs plus randomized operations with random output
// stalls and occasional flushes. Expected products come from plain integer
// multiplication of the extended operands.
module tb_booth_mul_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst32;
  logic rst8;

  booth_mul_pipe_if #(.WIDTH(32), .TAG_W(4)) b32 ();
  booth_mul_pipe_if #(.WIDTH(8),  .TAG_W(4)) b8 ();

  booth_mul_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (.clk(clk), .reset(rst32), .bus(b32));
  booth_mul_pipe #(.WIDTH(8),  .TAG_W(4)) dut8  (.clk(clk), .reset(rst8),  .bus(b8));

  // ---------------- scoreboard state ----------------
  logic [67:0] exp32_q[$];   // {tag, product}
  logic [19:0] exp8_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int streak32 = 0;
  int max_streak32 = 0;
  bit stall8_en = 1'b0;

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref32(input logic s, input logic [31:0] x, input logic [31:0] y);
    if (s) return $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
    return {32'b0, x} * {32'b0, y};
  endfunction

  function automatic logic [15:0] ref8(input logic s, input logic [7:0] x, input logic [7:0] y);
    if (s) return $signed({{8{x[7]}}, x}) * $signed({{8{y[7]}}, y});
    return {8'b0, x} * {8'b0, y};
  endfunction

  // ---------------- driver tasks (enter and leave at a falling edge) ----------------
  task automatic send32(input logic s, input logic [31:0] x, input logic [31:0] y,
                        input logic [3:0] t, output int tries);
    logic fired;
    fired = 1'b0;
    tries = 0;
    b32.in_valid  = 1'b1;
    b32.in_signed = s;
    b32.in_x      = x;
    b32.in_y      = y;
    b32.in_tag    = t;
    while (!fired && tries < 100) begin
      #1;
      tries++;
      if (b32.in_ready) begin
        fired = 1'b1;
        exp32_q.push_back({t, ref32(s, x, y)});
      end
      @(negedge clk);
    end
    if (!fired) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send32_timeout: in_ready stayed 0 for %0d cycles, required 1", tries);
    end
  endtask

  task automatic send8(input logic s, input logic [7:0] x, input logic [7:0] y, input logic [3:0] t);
    logic fired;
    int tries;
    fired = 1'b0;
    tries = 0;
    b8.in_valid  = 1'b1;
    b8.in_signed = s;
    b8.in_x      = x;
    b8.in_y      = y;
    b8.in_tag    = t;
    while (!fired && tries < 200) begin
      #1;
      tries++;
      if (b8.in_ready) begin
        fired = 1'b1;
        exp8_q.push_back({t, ref8(s, x, y)});
      end
      @(negedge clk);
    end
    if (!fired) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send8_timeout: in_ready stayed 0 for %0d cycles, required 1", tries);
    end
  endtask

  task automatic drain32();
    int n;
    n = 0;
    while (exp32_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain32_pending", 72'(exp32_q.size()), 72'(0));
  endtask

  task automatic drain8();
    int n;
    n = 0;
    while (exp8_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain8_pending", 72'(exp8_q.size()), 72'(0));
  endtask

  // One flush cycle on the 8-bit unit with an operation offered alongside it.
  task automatic flush8();
    b8.flush     = 1'b1;
    b8.in_valid  = 1'b1;
    b8.in_signed = 1'($urandom_range(0, 1));
    b8.in_x      = 8'($urandom);
    b8.in_y      = 8'($urandom);
    b8.in_tag    = 4'hF;
    #1;
    check("flush8_in_ready", 72'(b8.in_ready), 72'(0));
    @(posedge clk);
    #1;
    exp8_q.delete();
    @(negedge clk);
    b8.flush    = 1'b0;
    b8.in_valid = 1'b0;
    #1;
    check("flush8_out_valid", 72'(b8.out_valid), 72'(0));
    @(negedge clk);
  endtask

  // ---------------- monitors ----------------
  initial begin
    logic [67:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (b32.out_valid) begin
        streak32++;
        if (streak32 > max_streak32) max_streak32 = streak32;
      end else begin
        streak32 = 0;
      end
      if (b32.out_valid && b32.out_ready) begin
        if (exp32_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL out32_unexpected: got tag %h result %h, required no result",
                   b32.out_tag, b32.out_result);
        end else begin
          e = exp32_q.pop_front();
          check("out32", 72'({b32.out_tag, b32.out_result}), 72'(e));
        end
      end
    end
  end

  initial begin
    logic [19:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (b8.out_valid && b8.out_ready) begin
        if (exp8_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL out8_unexpected: got tag %h result %h, required no result",
                   b8.out_tag, b8.out_result);
        end else begin
          e = exp8_q.pop_front();
          check("out8", 72'({b8.out_tag, b8.out_result}), 72'(e));
        end
      end
    end
  end

  // Random backpressure on the 8-bit unit.
  initial begin
    b8.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      b8.out_ready = stall8_en ? ($urandom_range(0, 9) < 7) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  logic [7:0] corners [6];

  initial begin
    int tries;
    int sum_tries;
    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h81};

    rst32 = 1'b1;
    rst8  = 1'b1;
    b32.in_valid = 1'b0; b32.in_signed = 1'b0; b32.in_x = '0; b32.in_y = '0;
    b32.in_tag = '0; b32.flush = 1'b0; b32.out_ready = 1'b1;
    b8.in_valid = 1'b0; b8.in_signed = 1'b0; b8.in_x = '0; b8.in_y = '0;
    b8.in_tag = '0; b8.flush = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check("reset_in_ready32", 72'(b32.in_ready), 72'(0));
    check("reset_in_ready8", 72'(b8.in_ready), 72'(0));
    @(negedge clk);
    rst32 = 1'b0;
    rst8  = 1'b0;
    #1;
    check("post_reset_in_ready32", 72'(b32.in_ready), 72'(1));
    check("post_reset_in_ready8", 72'(b8.in_ready), 72'(1));
    check("post_reset_out32", 72'({b32.out_valid, b32.out_tag, b32.out_result}), 72'(0));
    check("post_reset_out8", 72'({b8.out_valid, b8.out_tag, b8.out_result}), 72'(0));
    @(negedge clk);

    // Latency: S1 after the accepting edge, S2 after the next one.
    send32(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3, tries);
    b32.in_valid = 1'b0;
    #1;
    check("latency_after_1_edge", 72'(b32.out_valid), 72'(0));
    @(negedge clk);
    #1;
    check("latency_after_2_edges", 72'(b32.out_valid), 72'(1));
    @(negedge clk);
    drain32();

    // Directed corner products.
    send32(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1, tries);
    send32(1'b1, 32'h80000000, 32'h80000000, 4'd2, tries);
    send32(1'b1, 32'h80000000, 32'h00000001, 4'd4, tries);
    send32(1'b0, 32'h80000000, 32'h00000001, 4'd5, tries);
    send32(1'b1, 32'h7FFFFFFF, 32'h80000000, 4'd6, tries);
    b32.in_valid = 1'b0;
    drain32();

    // Back-to-back issue of five operations.
    max_streak32 = 0;
    sum_tries = 0;
    for (int k = 0; k < 5; k++) begin
      send32(1'($urandom_range(0, 1)), $urandom, $urandom, 4'(k + 8), tries);
      sum_tries += tries;
    end
    b32.in_valid = 1'b0;
    drain32();
    check("b2b_accept_cycles", 72'(sum_tries), 72'(5));
    check("b2b_valid_streak", 72'(max_streak32), 72'(5));

    // Capacity: two accepted under backpressure, the third waits.
    b32.out_ready = 1'b0;
    send32(1'b1, 32'd1234, 32'hFFFFFF00, 4'hA, tries);
    send32(1'b0, 32'hDEADBEEF, 32'h12345678, 4'hB, tries);
    check("cap_second_accept", 72'(tries), 72'(1));
    b32.in_valid = 1'b1;
    b32.in_signed = 1'b1;
    b32.in_x = 32'h0000_0003;
    b32.in_y = 32'hFFFF_FFFD;
    b32.in_tag = 4'hC;
    #1;
    check("cap_third_blocked", 72'(b32.in_ready), 72'(0));
    @(negedge clk);
    b32.out_ready = 1'b1;
    send32(1'b1, 32'h0000_0003, 32'hFFFF_FFFD, 4'hC, tries);
    check("cap_third_same_cycle", 72'(tries), 72'(1));
    b32.in_valid = 1'b0;
    drain32();

    // Flush with two in flight and an operation offered.
    b32.out_ready = 1'b0;
    send32(1'b0, 32'd77, 32'd99, 4'h1, tries);
    send32(1'b1, 32'hFFFF_FFF0, 32'd5, 4'h2, tries);
    b32.flush = 1'b1;
    b32.in_x = 32'd3;
    b32.in_y = 32'd3;
    b32.in_tag = 4'h3;
    #1;
    check("flush_in_ready", 72'(b32.in_ready), 72'(0));
    @(posedge clk);
    #1;
    exp32_q.delete();
    @(negedge clk);
    b32.flush = 1'b0;
    b32.in_valid = 1'b0;
    b32.out_ready = 1'b1;
    #1;
    check("flush_out_valid", 72'(b32.out_valid), 72'(0));
    repeat (4) @(negedge clk);
    #1;
    check("flush_nothing_accepted", 72'(b32.out_valid), 72'(0));
    @(negedge clk);

    // Reset in the middle of a stream.
    b32.out_ready = 1'b0;
    send32(1'b0, 32'd5, 32'd7, 4'h5, tries);
    send32(1'b0, 32'd11, 32'd13, 4'h6, tries);
    rst32 = 1'b1;
    b32.in_x = 32'd2;
    b32.in_y = 32'd2;
    b32.in_tag = 4'h7;
    #1;
    check("reset_mid_in_ready", 72'(b32.in_ready), 72'(0));
    @(posedge clk);
    #1;
    exp32_q.delete();
    @(negedge clk);
    rst32 = 1'b0;
    b32.in_valid = 1'b0;
    b32.out_ready = 1'b1;
    #1;
    check("reset_mid_out", 72'({b32.out_valid, b32.out_tag, b32.out_result}), 72'(0));
    check("reset_mid_in_ready_after", 72'(b32.in_ready), 72'(1));
    @(negedge clk);
    send32(1'b1, 32'hFFFFFFFF, 32'h00000002, 4'h9, tries);
    b32.in_valid = 1'b0;
    drain32();

    // 8-bit unit: corner pairs in both modes, then random traffic.
    stall8_en = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++)
          send8(1'(s), corners[i], corners[j], 4'(i * 6 + j));
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        flush8();
      end else if ($urandom_range(0, 7) == 0) begin
        b8.in_valid = 1'b0;
        @(negedge clk);
      end
      send8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 4'(k));
    end
    b8.in_valid = 1'b0;
    stall8_en = 1'b0;
    drain8();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
